// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences CPU load/store requests onto the ram256x8 MOV/MOC handshake.
//   A request is latched in IDLE, address/control/data are presented to the
//   RAM one cycle before MOV rises, MOV is held until MOC (or a timeout), read
//   data is captured, and done pulses. Double-word requests become two word
//   accesses at A and A+4 (mod 256). Misaligned requests finish at once with
//   err and never touch the RAM.
//
// Handshake: ram_MOV rises only after the controls have been stable for one
//   cycle (SETUP), stays high with the controls frozen until ram_MOC=1 is
//   honoured, and drops for at least one cycle (RELEASE) before any further
//   access, so every access starts with a fresh MOV rising edge.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   req                 request strobe, sampled only while idle
//   rw                  1 = load, 0 = store
//   addr, dtype, sign   byte address, access size (00 B, 01 H, 10 W, 11 D),
//                       sign-extend for byte/half loads
//   wdata_hi, wdata_lo  store data (hi = word at A of a double)
//   busy, done, err     status; done/err are one-cycle pulses
//   rdata_hi, rdata_lo  load data (hi only meaningful for doubles)
//   ram_*               connection to ram256x8
module mem_access_ctrl #(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic [1:0]  dtype,
    input  logic        sign,
    input  logic [31:0] wdata_hi,
    input  logic [31:0] wdata_lo,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata_hi,
    output logic [31:0] rdata_lo,
    output logic        ram_MOV,
    output logic        ram_ReadWrite,
    output logic [7:0]  ram_Address,
    output logic [31:0] ram_DataIn,
    output logic [1:0]  ram_DataType,
    output logic        ram_SIGN,
    input  logic        ram_MOC,
    input  logic [31:0] ram_DataOut
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_WAIT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic          phase;      // 0 = first (or only) access, 1 = A+4 half of a double
    logic [CW-1:0] cnt;        // ACCESS cycles spent without an honoured MOC
    logic [1:0]    l_dtype;
    logic [31:0]   l_lo;       // second store word of a double
    logic          err_flag;   // timeout seen during this transaction
    logic          misaligned;
    logic          is_double;

    always_comb begin
        misaligned = 1'b0;
        case (dtype)
            2'b01:        misaligned = addr[0];
            2'b10, 2'b11: misaligned = |addr[1:0];
            default:      misaligned = 1'b0;
        endcase
    end

    assign is_double = (l_dtype == 2'b11);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= S_IDLE;
            phase         <= 1'b0;
            cnt           <= '0;
            l_dtype       <= 2'b00;
            l_lo          <= 32'h0;
            err_flag      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata_hi      <= 32'h0;
            rdata_lo      <= 32'h0;
            ram_MOV       <= 1'b0;
            ram_ReadWrite <= 1'b0;
            ram_Address   <= 8'h0;
            ram_DataIn    <= 32'h0;
            ram_DataType  <= 2'b00;
            ram_SIGN      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (req) begin
                        busy    <= 1'b1;
                        l_dtype <= dtype;
                        l_lo    <= wdata_lo;
                        if (misaligned) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            // Outputs are registered, so the RAM sees these
                            // values during the SETUP cycle itself.
                            state         <= S_SETUP;
                            phase         <= 1'b0;
                            err_flag      <= 1'b0;
                            ram_Address   <= addr;
                            ram_ReadWrite <= rw;
                            ram_DataType  <= (dtype == 2'b11) ? 2'b10 : dtype;
                            ram_SIGN      <= sign;
                            ram_DataIn    <= (dtype == 2'b11) ? wdata_hi : wdata_lo;
                        end
                    end
                end

                S_SETUP: begin
                    ram_MOV <= 1'b1;
                    cnt     <= '0;
                    state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (ram_MOC && (cnt >= CNT_MIN)) begin
                        if (ram_ReadWrite) begin
                            if (is_double && !phase) begin
                                rdata_hi <= ram_DataOut;
                            end else begin
                                rdata_lo <= ram_DataOut;
                                if (!is_double) rdata_hi <= 32'h0;
                            end
                        end
                        ram_MOV <= 1'b0;
                        state   <= S_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        err_flag <= 1'b1;
                        ram_MOV  <= 1'b0;
                        state    <= S_RELEASE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_RELEASE: begin
                    if (is_double && !phase && !err_flag) begin
                        // Second word; address wraps naturally at 8 bits.
                        phase       <= 1'b1;
                        ram_Address <= ram_Address + 8'd4;
                        ram_DataIn  <= l_lo;
                        state       <= S_SETUP;
                    end else begin
                        done  <= 1'b1;
                        err   <= err_flag;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    ram_MOV <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Drives mem_access_ctrl against a behavioural ram256x8 (big-endian, MOC
//   after a programmable number of MOV cycles, or never) and compares every
//   transaction with a reference memory image kept separately in the bench.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req;
  logic        rw;
  logic [7:0]  addr;
  logic [1:0]  dtype;
  logic        sign;
  logic [31:0] wdata_hi;
  logic [31:0] wdata_lo;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata_hi;
  logic [31:0] rdata_lo;
  logic        ram_MOV;
  logic        ram_ReadWrite;
  logic [7:0]  ram_Address;
  logic [31:0] ram_DataIn;
  logic [1:0]  ram_DataType;
  logic        ram_SIGN;
  logic        ram_MOC;
  logic [31:0] ram_DataOut;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.MIN_WAIT(1), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .rw(rw), .addr(addr), .dtype(dtype),
    .sign(sign), .wdata_hi(wdata_hi), .wdata_lo(wdata_lo), .busy(busy),
    .done(done), .err(err), .rdata_hi(rdata_hi), .rdata_lo(rdata_lo),
    .ram_MOV(ram_MOV), .ram_ReadWrite(ram_ReadWrite), .ram_Address(ram_Address),
    .ram_DataIn(ram_DataIn), .ram_DataType(ram_DataType), .ram_SIGN(ram_SIGN),
    .ram_MOC(ram_MOC), .ram_DataOut(ram_DataOut)
  );

  // ---------------- behavioural RAM ----------------
  logic [7:0] init_mem [256];
  logic [7:0] ram_mem [256];
  logic       ram_load;
  logic       moc_kill;
  int         moc_delay;
  int         moc_cnt;
  logic [7:0] b0, b1, b2, b3;

  assign b0 = ram_mem[ram_Address];
  assign b1 = ram_mem[ram_Address + 8'd1];
  assign b2 = ram_mem[ram_Address + 8'd2];
  assign b3 = ram_mem[ram_Address + 8'd3];
  assign ram_MOC = ram_MOV && !moc_kill && (moc_cnt >= moc_delay);

  always_comb begin
    ram_DataOut = {b0, b1, b2, b3};
    case (ram_DataType)
      2'b00:   ram_DataOut = ram_SIGN ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   ram_DataOut = ram_SIGN ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      default: ram_DataOut = {b0, b1, b2, b3};
    endcase
  end

  always @(posedge Clk) begin
    if (!ram_MOV) moc_cnt <= 0;
    else          moc_cnt <= moc_cnt + 1;
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_mem[i];
    end else if (ram_MOV && ram_MOC && !ram_ReadWrite) begin
      case (ram_DataType)
        2'b00: ram_mem[ram_Address] <= ram_DataIn[7:0];
        2'b01: begin
          ram_mem[ram_Address]        <= ram_DataIn[15:8];
          ram_mem[ram_Address + 8'd1] <= ram_DataIn[7:0];
        end
        default: begin
          ram_mem[ram_Address]        <= ram_DataIn[31:24];
          ram_mem[ram_Address + 8'd1] <= ram_DataIn[23:16];
          ram_mem[ram_Address + 8'd2] <= ram_DataIn[15:8];
          ram_mem[ram_Address + 8'd3] <= ram_DataIn[7:0];
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
  endfunction

  task automatic put_word(input logic [7:0] a, input logic [31:0] w);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    ref_mem[a] = w[31:24]; ref_mem[a1] = w[23:16];
    ref_mem[a2] = w[15:8]; ref_mem[a3] = w[7:0];
  endtask

  task automatic model_txn(input logic m_rw, input logic [7:0] a, input logic [1:0] dt,
                           input logic s, input logic [31:0] hi, input logic [31:0] lo,
                           output logic m_err);
    logic [7:0] a1, a4;
    int v;
    a1 = a + 8'd1;
    a4 = a + 8'd4;
    m_err = ((dt == 2'b01) && (a % 2 != 0)) || ((dt >= 2'b10) && (a % 4 != 0));
    if (!m_err) begin
      if (m_rw) begin
        case (dt)
          2'b00: begin
            v = ref_mem[a];
            if (s && v >= 128) v = v - 256;
            exp_lo = 32'(v); exp_hi = 32'h0;
          end
          2'b01: begin
            v = ref_mem[a] * 256 + ref_mem[a1];
            if (s && v >= 32768) v = v - 65536;
            exp_lo = 32'(v); exp_hi = 32'h0;
          end
          2'b10: begin exp_lo = word_at(a); exp_hi = 32'h0; end
          default: begin exp_hi = word_at(a); exp_lo = word_at(a4); end
        endcase
      end else begin
        case (dt)
          2'b00: ref_mem[a] = lo[7:0];
          2'b01: begin ref_mem[a] = lo[15:8]; ref_mem[a1] = lo[7:0]; end
          2'b10: put_word(a, lo);
          default: begin put_word(a, hi); put_word(a4, lo); end
        endcase
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input string tag, input logic t_rw, input logic [7:0] a,
                        input logic [1:0] dt, input logic s, input logic [31:0] hi,
                        input logic [31:0] lo, input int d, input bit tmo);
    logic e_err, done_seen, mov_seen, mov_prev, busy1, g_err;
    int   e_cyc, cyc;
    moc_delay = d;
    if (tmo) begin
      e_err = 1'b1;
      e_cyc = 3 + TIMEOUT;
    end else begin
      model_txn(t_rw, a, dt, s, hi, lo, e_err);
      e_cyc = e_err ? 1 : ((dt == 2'b11) ? 7 + 2 * d : 4 + d);
    end
    @(negedge Clk);
    req = 1'b1; rw = t_rw; addr = a; dtype = dt; sign = s; wdata_hi = hi; wdata_lo = lo;
    cyc = 0; done_seen = 0; mov_seen = 0; mov_prev = 0; busy1 = 0; g_err = 0;
    while (!done_seen && cyc < 100) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (cyc == 1) busy1 = busy;
      if (done) begin
        done_seen = 1'b1;
        g_err = err;
      end else begin
        if (ram_MOV) mov_seen = 1'b1;
        mov_prev = ram_MOV;
        // requests while busy must be ignored
        req = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
        addr = 8'($urandom); dtype = 2'($urandom); wdata_hi = $urandom; wdata_lo = $urandom;
      end
    end
    req = 1'b0;
    check($sformatf("%s_done", tag), 32'(done_seen), 32'd1);
    check($sformatf("%s_cycles", tag), 32'(cyc), 32'(e_cyc));
    check($sformatf("%s_busy", tag), 32'(busy1), 32'd1);
    check($sformatf("%s_err", tag), 32'(g_err), 32'(e_err));
    if (e_err && !tmo) check($sformatf("%s_mov_untouched", tag), 32'(mov_seen), 32'd0);
    else               check($sformatf("%s_mov_released", tag), 32'(mov_prev), 32'd0);
    check($sformatf("%s_rdata_hi", tag), rdata_hi, exp_hi);
    check($sformatf("%s_rdata_lo", tag), rdata_lo, exp_lo);
    @(negedge Clk);
    check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_idle_done", tag), 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_done", tag), 32'(done), 32'd0);
    check($sformatf("%s_err", tag), 32'(err), 32'd0);
    check($sformatf("%s_rdata_hi", tag), rdata_hi, 32'h0);
    check($sformatf("%s_rdata_lo", tag), rdata_lo, 32'h0);
    check($sformatf("%s_mov", tag), 32'(ram_MOV), 32'd0);
    check($sformatf("%s_ramctl", tag),
          {ram_ReadWrite, ram_SIGN, ram_DataType, ram_Address}, 32'h0);
    check($sformatf("%s_datain", tag), ram_DataIn, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          wait_cyc;
    logic        r_rw, r_s;
    logic [7:0]  r_a;
    logic [1:0]  r_dt;
    n_checks = 0; n_errors = 0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
    init_mem[8'h10] = 8'hDE; init_mem[8'h11] = 8'hAD;
    init_mem[8'h12] = 8'hBE; init_mem[8'h13] = 8'hEF;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];
    Reset = 1'b1; ram_load = 1'b1; moc_kill = 1'b0; moc_delay = 0;
    req = 1'b0; rw = 1'b0; addr = 8'h0; dtype = 2'b00; sign = 1'b0;
    wdata_hi = 32'h0; wdata_lo = 32'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_outputs("reset");
    Reset = 1'b0; ram_load = 1'b0;

    do_txn("rd_word_10", 1'b1, 8'h10, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0);
    do_txn("wr_dbl_20", 1'b0, 8'h20, 2'b11, 1'b0, 32'h11223344, 32'h55667788, 0, 0);
    do_txn("rd_dbl_20", 1'b1, 8'h20, 2'b11, 1'b0, 32'h0, 32'h0, 0, 0);
    do_txn("rd_byte_s1", 1'b1, 8'h10, 2'b00, 1'b1, 32'h0, 32'h0, 0, 0);
    do_txn("rd_byte_s0", 1'b1, 8'h10, 2'b00, 1'b0, 32'h0, 32'h0, 0, 0);
    do_txn("rd_half_s1", 1'b1, 8'h12, 2'b01, 1'b1, 32'h0, 32'h0, 0, 0);
    do_txn("rd_half_mis", 1'b1, 8'h11, 2'b01, 1'b0, 32'h0, 32'h0, 0, 0);
    do_txn("wr_word_mis", 1'b0, 8'h22, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 0, 0);
    do_txn("wr_dbl_fc", 1'b0, 8'hFC, 2'b11, 1'b0, 32'hA1A2A3A4, 32'hB1B2B3B4, 0, 0);
    do_txn("rd_dbl_fc", 1'b1, 8'hFC, 2'b11, 1'b0, 32'h0, 32'h0, 1, 0);
    do_txn("rd_word_00", 1'b1, 8'h00, 2'b10, 1'b0, 32'h0, 32'h0, 2, 0);

    moc_kill = 1'b1;
    do_txn("timeout", 1'b1, 8'h10, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1);

    // reset in the middle of a double access (MOC held off)
    @(negedge Clk);
    req = 1'b1; rw = 1'b1; addr = 8'h20; dtype = 2'b11;
    @(posedge Clk);
    #1 req = 1'b0;
    wait_cyc = 0;
    @(negedge Clk);
    while (!ram_MOV && wait_cyc < 10) begin
      @(negedge Clk);
      wait_cyc++;
    end
    check("rst_mid_mov_seen", 32'(ram_MOV), 32'd1);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    moc_kill = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    check_reset_outputs("rst_mid");
    repeat (3) begin
      @(negedge Clk);
      check("rst_mid_no_done", 32'(done | busy | ram_MOV), 32'd0);
    end
    do_txn("after_rst", 1'b1, 8'h10, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      r_rw = 1'($urandom_range(0, 1));
      r_dt = 2'($urandom_range(0, 3));
      r_s  = 1'($urandom_range(0, 1));
      r_a  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 85) begin
        if (r_dt == 2'b01) r_a[0] = 1'b0;
        else if (r_dt[1]) r_a[1:0] = 2'b00;
      end
      do_txn($sformatf("rnd%0d", n), r_rw, r_a, r_dt, r_s, $urandom, $urandom,
             int'($urandom_range(0, 3)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
